cfg_sequencer: RTL and testbench

- Parametrised successor to the single-device configuration reader.
- Walks a synchronous configuration ROM holding register tables for NUM_DEVICES I2C devices, e.g. the TVP5147 decoder and a companion encoder.
- Issues one write transaction per (sub-address, data) pair to the existing i2c master controller.
- Adds NACK retry, a busy-handshake timeout, optional read-back verify, and per-device completion flags.

---
 rtl/cfg_seq_pkg.sv | 29 ++
 rtl/cfg_rom_fetch.sv | 40 ++++
 rtl/cfg_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_cfg_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the configuration ROM sequencer.
// Holds the FSM state encoding, table header offsets and I2C R/W bit values.
package cfg_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_DEV,
    RD_CNT,
    RD_SUB,
    RD_DATA,
    REQ,
    WAIT_HI,
    WAIT_LO,
    VREQ,
    VWAIT_HI,
    VWAIT_LO,
    NEXT,
    DONE,
    ERR
  } seq_state_e;

  // Byte offsets inside a device table header
  localparam int DEV_OFS = 0;
  localparam int CNT_OFS = 1;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/cfg_rom_fetch.sv
// Single-outstanding read port for a synchronous ROM with fixed latency.
// A req pulse launches the address; valid marks the one cycle q is usable.
module cfg_rom_fetch #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_q,
  output logic              active,
  output logic              valid,
  output logic [7:0]        q
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      wait_cnt <= '0;
      active   <= 1'b0;
    end else if (req) begin
      rom_addr <= addr;
      wait_cnt <= CNT_W'(LATENCY);
      active   <= 1'b1;
    end else if (active) begin
      if (wait_cnt == '0) active <= 1'b0;
      else                wait_cnt <= wait_cnt - 1'b1;
    end
  end

  assign valid = active && (wait_cnt == '0);
  assign q     = rom_q;

endmodule

// File: rtl/cfg_sequencer.sv
// Walks per-device register tables in ROM and issues one I2C write per pair,
// with NACK retry, busy-phase timeout, optional read-back verify and per-device flags.
module cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int NUM_DEVICES    = 2,
  parameter int ROM_ADDR_W     = 8,
  parameter int ROM_LATENCY    = 1,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int VERIFY_EN      = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [ROM_ADDR_W-1:0]          rom_addr,
  input  logic [7:0]                     rom_q,
  output logic [7:0]                     i2c_addr_w_rw,
  output logic [7:0]                     i2c_sub_addr,
  output logic [7:0]                     i2c_data_write,
  output logic                           i2c_req_trans,
  input  logic                           i2c_busy,
  input  logic                           i2c_nack,
  input  logic [7:0]                     i2c_rd_data,
  input  logic                           i2c_rd_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(NUM_DEVICES):0]   err_dev,
  output logic [ROM_ADDR_W-1:0]          err_addr,
  output logic [NUM_DEVICES-1:0]         inited_devices
);

  localparam int DEV_W   = $clog2(NUM_DEVICES) + 1;
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e state_q, next_state;

  logic [ROM_ADDR_W-1:0]  dev_base_q, ptr_q, sub_ptr_q;
  logic [6:0]             dev_addr_q;
  logic [7:0]             sub_q, data_q, remaining_q, rd_byte_q;
  logic                   rd_got_q;
  logic [RETRY_W-1:0]     retry_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [DEV_W-1:0]       dev_idx_q;
  logic [NUM_DEVICES-1:0] inited_q;
  logic [DEV_W-1:0]       err_dev_q;
  logic [ROM_ADDR_W-1:0]  err_addr_q;

  logic                  fetch_req, fetch_active, fetch_valid;
  logic [ROM_ADDR_W-1:0] fetch_addr;
  logic [7:0]            fetch_q;

  logic seq_start, retry_inc, retry_clr, dev_finish, err_latch, xfer_fail;
  logic tmo_expired, rd_match, verify_phase;

  cfg_rom_fetch #(
    .ADDR_W  (ROM_ADDR_W),
    .LATENCY (ROM_LATENCY)
  ) u_fetch (
    .clk      (clk),
    .reset    (reset),
    .req      (fetch_req),
    .addr     (fetch_addr),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .active   (fetch_active),
    .valid    (fetch_valid),
    .q        (fetch_q)
  );

  assign tmo_expired = (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1));
  // The strobe may coincide with the busy fall, so accept it directly too
  assign rd_match = (rd_got_q && (rd_byte_q == data_q)) ||
                    (i2c_rd_valid && (i2c_rd_data == data_q));

  always_comb begin
    next_state = state_q;
    fetch_req  = 1'b0;
    fetch_addr = ptr_q;
    seq_start  = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    dev_finish = 1'b0;
    err_latch  = 1'b0;
    xfer_fail  = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: if (start) begin
        next_state = RD_DEV;
        seq_start  = 1'b1;
      end
      RD_DEV: begin
        fetch_addr = dev_base_q + ROM_ADDR_W'(DEV_OFS);
        if (fetch_valid)        next_state = RD_CNT;
        else if (!fetch_active) fetch_req  = 1'b1;
      end
      RD_CNT: begin
        fetch_addr = dev_base_q + ROM_ADDR_W'(CNT_OFS);
        if (fetch_valid)        next_state = (fetch_q == 8'd0) ? NEXT : RD_SUB;
        else if (!fetch_active) fetch_req  = 1'b1;
      end
      RD_SUB: begin
        if (fetch_valid)        next_state = RD_DATA;
        else if (!fetch_active) fetch_req  = 1'b1;
      end
      RD_DATA: begin
        if (fetch_valid)        next_state = REQ;
        else if (!fetch_active) fetch_req  = 1'b1;
      end
      REQ:  next_state = WAIT_HI;
      VREQ: next_state = VWAIT_HI;
      WAIT_HI, VWAIT_HI: begin
        if (i2c_busy)         next_state = (state_q == WAIT_HI) ? WAIT_LO : VWAIT_LO;
        else if (tmo_expired) begin
          next_state = ERR;
          err_latch  = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!i2c_busy) begin
          if (i2c_nack) xfer_fail  = 1'b1;
          else          next_state = (VERIFY_EN != 0) ? VREQ : NEXT;
        end else if (tmo_expired) begin
          next_state = ERR;
          err_latch  = 1'b1;
        end
      end
      VWAIT_LO: begin
        if (!i2c_busy) begin
          if (i2c_nack || !rd_match) xfer_fail  = 1'b1;
          else                       next_state = NEXT;
        end else if (tmo_expired) begin
          next_state = ERR;
          err_latch  = 1'b1;
        end
      end
      NEXT: begin
        retry_clr = 1'b1;
        if (remaining_q != 8'd0) begin
          next_state = RD_SUB;
        end else begin
          dev_finish = 1'b1;
          next_state = ((dev_idx_q + 1'b1) == DEV_W'(NUM_DEVICES)) ? DONE : RD_DEV;
        end
      end
      default: next_state = IDLE;
    endcase
    // Write NACK and verify mismatch share one retry budget per register
    if (xfer_fail) begin
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_inc  = 1'b1;
        next_state = REQ;
      end else begin
        next_state = ERR;
        err_latch  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dev_base_q  <= '0;
      ptr_q       <= '0;
      sub_ptr_q   <= '0;
      dev_addr_q  <= '0;
      sub_q       <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      rd_byte_q   <= '0;
      rd_got_q    <= 1'b0;
      retry_q     <= '0;
      tmo_q       <= '0;
      dev_idx_q   <= '0;
      inited_q    <= '0;
      err_dev_q   <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q <= next_state;
      if (state_q != next_state) tmo_q <= '0;
      else if (tmo_q != '1)      tmo_q <= tmo_q + 1'b1;

      if (seq_start) begin
        dev_base_q <= '0;
        ptr_q      <= '0;
        dev_idx_q  <= '0;
        inited_q   <= '0;
        retry_q    <= '0;
        err_dev_q  <= '0;
        err_addr_q <= '0;
      end

      if (fetch_valid) begin
        unique case (state_q)
          RD_DEV: dev_addr_q <= fetch_q[7:1];
          RD_CNT: begin
            remaining_q <= fetch_q;
            ptr_q       <= dev_base_q + ROM_ADDR_W'(CNT_OFS + 1);
          end
          RD_SUB: begin
            sub_q     <= fetch_q;
            sub_ptr_q <= ptr_q;
            ptr_q     <= ptr_q + 1'b1;
          end
          RD_DATA: begin
            data_q      <= fetch_q;
            ptr_q       <= ptr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
          end
          default: ;
        endcase
      end

      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + 1'b1;

      if (dev_finish) begin
        inited_q   <= inited_q | (NUM_DEVICES'(1) << dev_idx_q);
        dev_idx_q  <= dev_idx_q + 1'b1;
        dev_base_q <= ptr_q;
      end

      if (err_latch) begin
        err_dev_q  <= dev_idx_q;
        err_addr_q <= sub_ptr_q;
      end

      if (state_q == VREQ) begin
        rd_got_q <= 1'b0;
      end else if (i2c_rd_valid && (state_q == VWAIT_HI || state_q == VWAIT_LO)) begin
        rd_got_q  <= 1'b1;
        rd_byte_q <= i2c_rd_data;
      end
    end
  end

  assign verify_phase   = (state_q == VREQ) || (state_q == VWAIT_HI) || (state_q == VWAIT_LO);
  assign i2c_addr_w_rw  = {dev_addr_q, verify_phase ? RW_READ : RW_WRITE};
  assign i2c_sub_addr   = sub_q;
  assign i2c_data_write = data_q;
  assign i2c_req_trans  = (state_q == REQ) || (state_q == WAIT_HI) ||
                          (state_q == VREQ) || (state_q == VWAIT_HI);
  assign busy           = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign done           = (state_q == DONE);
  assign error          = (state_q == ERR);
  assign err_dev        = err_dev_q;
  assign err_addr       = err_addr_q;
  assign inited_devices = inited_q;

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer: one write-only instance and one verify instance
// share a ROM image and a behavioural I2C master; a scoreboard checks transaction triples.
module tb_cfg_sequencer;

  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_r, sel, m_silent;
  logic start0, start1;
  assign start0 = start_r & ~sel;
  assign start1 = start_r & sel;

  logic [7:0] rom [256];
  logic [7:0] rom_q0, rom_q1;
  logic       i2c_busy, i2c_nack, i2c_rd_valid;
  logic [7:0] i2c_rd_data;

  logic [7:0] d0_rom_addr, d0_addr_rw, d0_sub, d0_data, d0_err_addr;
  logic       d0_req, d0_busy, d0_done, d0_error;
  logic [1:0] d0_err_dev, d0_inited;
  logic [7:0] d1_rom_addr, d1_addr_rw, d1_sub, d1_data, d1_err_addr;
  logic       d1_req, d1_busy, d1_done, d1_error;
  logic [1:0] d1_err_dev, d1_inited;

  cfg_sequencer #(.NUM_DEVICES(2), .ROM_ADDR_W(8), .ROM_LATENCY(1), .MAX_RETRY(3),
                  .TIMEOUT_CYCLES(TMO), .VERIFY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .rom_addr(d0_rom_addr), .rom_q(rom_q0),
    .i2c_addr_w_rw(d0_addr_rw), .i2c_sub_addr(d0_sub), .i2c_data_write(d0_data),
    .i2c_req_trans(d0_req), .i2c_busy(i2c_busy), .i2c_nack(i2c_nack),
    .i2c_rd_data(i2c_rd_data), .i2c_rd_valid(i2c_rd_valid), .busy(d0_busy),
    .done(d0_done), .error(d0_error), .err_dev(d0_err_dev), .err_addr(d0_err_addr),
    .inited_devices(d0_inited));

  cfg_sequencer #(.NUM_DEVICES(2), .ROM_ADDR_W(8), .ROM_LATENCY(1), .MAX_RETRY(3),
                  .TIMEOUT_CYCLES(TMO), .VERIFY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rom_addr(d1_rom_addr), .rom_q(rom_q1),
    .i2c_addr_w_rw(d1_addr_rw), .i2c_sub_addr(d1_sub), .i2c_data_write(d1_data),
    .i2c_req_trans(d1_req), .i2c_busy(i2c_busy), .i2c_nack(i2c_nack),
    .i2c_rd_data(i2c_rd_data), .i2c_rd_valid(i2c_rd_valid), .busy(d1_busy),
    .done(d1_done), .error(d1_error), .err_dev(d1_err_dev), .err_addr(d1_err_addr),
    .inited_devices(d1_inited));

  // Selected instance as seen by the master model and the checks
  logic [7:0] m_rom_addr, m_addr_rw, m_sub, m_data, m_err_addr;
  logic       m_req, m_busy, m_done, m_error;
  logic [1:0] m_err_dev, m_inited;
  assign m_rom_addr = sel ? d1_rom_addr : d0_rom_addr;
  assign m_addr_rw  = sel ? d1_addr_rw  : d0_addr_rw;
  assign m_sub      = sel ? d1_sub      : d0_sub;
  assign m_data     = sel ? d1_data     : d0_data;
  assign m_err_addr = sel ? d1_err_addr : d0_err_addr;
  assign m_req      = sel ? d1_req      : d0_req;
  assign m_busy     = sel ? d1_busy     : d0_busy;
  assign m_done     = sel ? d1_done     : d0_done;
  assign m_error    = sel ? d1_error    : d0_error;
  assign m_err_dev  = sel ? d1_err_dev  : d0_err_dev;
  assign m_inited   = sel ? d1_inited   : d0_inited;

  always @(posedge clk) begin
    rom_q0 <= rom[d0_rom_addr];
    rom_q1 <= rom[d1_rom_addr];
  end

  // ---------------- I2C master model ----------------
  logic [23:0] obs_q[$];
  logic [7:0]  dev_mem [256];
  logic [7:0]  t_addr, t_sub, t_data, nack_sub;
  int nack_total = 0, nack_until = 0, corrupt_total = 0, corrupt_until = 0;

  initial begin
    i2c_busy = 1'b0; i2c_nack = 1'b0; i2c_rd_data = 8'h00; i2c_rd_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_req && !m_silent && !reset) begin
        t_addr = m_addr_rw; t_sub = m_sub; t_data = m_data;
        obs_q.push_back({t_addr, t_sub, t_data});
        i2c_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        if (t_addr[0]) begin
          i2c_rd_data = dev_mem[t_sub];
          if (corrupt_total < corrupt_until) begin
            i2c_rd_data = i2c_rd_data ^ 8'h01;
            corrupt_total++;
          end
          i2c_rd_valid = 1'b1;
          @(posedge clk); #1;
          i2c_rd_valid = 1'b0;
        end else begin
          dev_mem[t_sub] = t_data;
        end
        if (!t_addr[0] && t_sub == nack_sub && nack_total < nack_until) begin
          i2c_nack = 1'b1;
          nack_total++;
        end
        i2c_busy = 1'b0;
        @(posedge clk); #1;
        i2c_nack = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  logic [23:0] exp_q[$];
  int obs_base = 0;
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'hB8; rom[1] = 8'h03;
    rom[2] = 8'h01; rom[3] = 8'h11;
    rom[4] = 8'h02; rom[5] = 8'h22;
    rom[6] = 8'h03; rom[7] = 8'h33;
    rom[8] = 8'h40; rom[9] = 8'h01;
    rom[10] = 8'h10; rom[11] = 8'hAA;
  endtask

  task automatic exp_txn(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d);
    exp_q.push_back({a, s, d});
  endtask

  task automatic exp_full_write_run();
    exp_txn(8'hB8, 8'h01, 8'h11);
    exp_txn(8'hB8, 8'h02, 8'h22);
    exp_txn(8'hB8, 8'h03, 8'h33);
    exp_txn(8'h40, 8'h10, 8'hAA);
  endtask

  task automatic check_txns(input string tag);
    int n;
    n = obs_q.size() - obs_base;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check({tag, "_txn"}, obs_q[obs_base + i], exp_q[i]);
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
  endtask

  task automatic run_to_end(input string tag);
    int n;
    pulse_start();
    n = 0;
    while (!(m_done || m_error) && n < 4000) begin @(negedge clk); n++; end
    check({tag, "_end"}, m_done | m_error, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {m_req, m_busy, m_done, m_error, m_inited, m_err_dev}, 8'h00);
    check({tag, "_bus"}, {m_addr_rw, m_sub, m_data}, 24'h0);
    check({tag, "_addr"}, {m_rom_addr, m_err_addr}, 16'h0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    reset = 1'b1; start_r = 1'b0; sel = 1'b0; m_silent = 1'b0; nack_sub = 8'h00;
    load_rom();
    repeat (3) @(negedge clk);
    check_all_zero("rst_d0");
    sel = 1'b1; #1;
    check_all_zero("rst_d1");
    sel = 1'b0;
    @(negedge clk); reset = 1'b0;

    // Two devices, all ACK
    exp_full_write_run();
    run_to_end("basic");
    check("basic_done", {m_done, m_error, m_busy}, 3'b100);
    check("basic_inited", m_inited, 2'b11);
    check_txns("basic");

    // Device 1 has no pairs
    rom[9] = 8'h00;
    exp_txn(8'hB8, 8'h01, 8'h11);
    exp_txn(8'hB8, 8'h02, 8'h22);
    exp_txn(8'hB8, 8'h03, 8'h33);
    run_to_end("empty");
    check("empty_done", m_done, 1'b1);
    check("empty_inited", m_inited, 2'b11);
    check_txns("empty");
    rom[9] = 8'h01;

    // Two NACKs on pair 2 then ACK: pair 2 issued three times
    nack_sub = 8'h02; nack_until = nack_total + 2;
    exp_txn(8'hB8, 8'h01, 8'h11);
    repeat (3) exp_txn(8'hB8, 8'h02, 8'h22);
    exp_txn(8'hB8, 8'h03, 8'h33);
    exp_txn(8'h40, 8'h10, 8'hAA);
    run_to_end("retry");
    check("retry_done", {m_done, m_error}, 2'b10);
    check("retry_inited", m_inited, 2'b11);
    check_txns("retry");

    // Four NACKs exhaust MAX_RETRY=3
    nack_until = nack_total + 4;
    exp_txn(8'hB8, 8'h01, 8'h11);
    repeat (4) exp_txn(8'hB8, 8'h02, 8'h22);
    run_to_end("nack");
    check("nack_err", {m_done, m_error, m_busy}, 3'b010);
    check("nack_err_dev", m_err_dev, 2'd0);
    check("nack_err_addr", m_err_addr, 8'd4);
    check("nack_inited", m_inited, 2'b00);
    check_txns("nack");

    // Master never answers: REQ cycle plus TMO cycles in WAIT_HI, then ERR
    m_silent = 1'b1;
    pulse_start();
    n = 0;
    while (!m_req && n < 200) begin @(negedge clk); n++; end
    check("tmo_req_seen", m_req, 1'b1);
    n = 0;
    while (!m_error && n < 300) begin @(posedge clk); n++; @(negedge clk); end
    check("tmo_error", m_error, 1'b1);
    check("tmo_clocks", n, TMO + 1);
    check("tmo_req_low", m_req, 1'b0);
    check("tmo_err_addr", {m_err_dev, m_err_addr}, {2'd0, 8'd2});
    m_silent = 1'b0;

    // Reset while device 1's write is in WAIT_LO
    pulse_start();
    n = 0;
    while (!(i2c_busy && m_sub == 8'h10) && n < 4000) begin @(negedge clk); n++; end
    check("wlo_reached", {i2c_busy, m_sub}, {1'b1, 8'h10});
    @(negedge clk);
    check("wlo_inited", m_inited, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b0;
    n = 0;
    while (i2c_busy && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    obs_base = obs_q.size();
    exp_full_write_run();
    run_to_end("rerun");
    check("rerun_done", m_done, 1'b1);
    check("rerun_inited", m_inited, 2'b11);
    check_txns("rerun");

    // Verify instance: first read-back corrupted -> one rewrite plus one re-read
    sel = 1'b1;
    corrupt_until = corrupt_total + 1;
    repeat (2) begin exp_txn(8'hB8, 8'h01, 8'h11); exp_txn(8'hB9, 8'h01, 8'h11); end
    exp_txn(8'hB8, 8'h02, 8'h22); exp_txn(8'hB9, 8'h02, 8'h22);
    exp_txn(8'hB8, 8'h03, 8'h33); exp_txn(8'hB9, 8'h03, 8'h33);
    exp_txn(8'h40, 8'h10, 8'hAA); exp_txn(8'h41, 8'h10, 8'hAA);
    run_to_end("verify");
    check("verify_done", {m_done, m_error}, 2'b10);
    check("verify_inited", m_inited, 2'b11);
    check_txns("verify");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
